dm_axi_read_engine: RTL and testbench

//  AXI4 read-channel slave engine inside the data-memory wrapper (DM_wrapper).

---
 rtl/dm_axi_read_engine.sv | 181 ++++++++++++++++++
 tb/tb_dm_axi_read_engine.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_axi_read_engine.sv
// AXI4 read-channel slave engine for the data-memory wrapper.
// Takes one AR burst at a time and turns it into single-port SRAM word reads.
// Read data goes back on R through a 2-entry skid buffer, at up to one beat per cycle.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
// A source that raises valid keeps valid and its payload stable until that edge.
// A ready may be raised or lowered at any time and does not wait for valid.
module dm_axi_read_engine #(
  parameter int ID_WIDTH   = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int SRAM_AW    = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] BASE_ADDR,
  input  logic [ID_WIDTH-1:0]   ARID_S,
  input  logic [ADDR_WIDTH-1:0] ARADDR_S,
  input  logic [LEN_WIDTH-1:0]  ARLEN_S,
  input  logic [2:0]            ARSIZE_S,
  input  logic [1:0]            ARBURST_S,
  input  logic                  ARVALID_S,
  output logic                  ARREADY_S,
  output logic [ID_WIDTH-1:0]   RID_S,
  output logic [DATA_WIDTH-1:0] RDATA_S,
  output logic [1:0]            RRESP_S,
  output logic                  RLAST_S,
  output logic                  RVALID_S,
  input  logic                  RREADY_S,
  output logic                  SRAM_CS,
  output logic [SRAM_AW-1:0]    SRAM_A,
  input  logic [DATA_WIDTH-1:0] SRAM_DO,
  output logic [1:0]            dbg_state
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // S_INIT holds ARREADY low for one cycle after reset before IDLE accepts bursts.
  typedef enum logic [1:0] {S_INIT = 2'd0, S_IDLE = 2'd1, S_BURST = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic                    ar_hs, pop, push, issue;
  logic [ADDR_WIDTH-1:0]   ar_offset;
  logic [1:0]              ar_resp;
  logic [ID_WIDTH-1:0]     id_q;
  logic [LEN_WIDTH-1:0]    len_q;
  logic                    fixed_q;
  logic [ADDR_WIDTH-1:0]   offset_q;
  logic [1:0]              resp_q;
  logic [LEN_WIDTH:0]      issued_q;
  logic                    inflight_q, inflight_last_q;
  logic [2:0]              occ;
  logic [DATA_WIDTH-1:0]   push_data;
  logic [DATA_WIDTH-1:0]   d0_q, d1_q;
  logic [1:0]              r0_q, r1_q;
  logic                    l0_q, l1_q;
  logic [1:0]              cnt_q;

  assign ar_offset = ARADDR_S - BASE_ADDR;
  assign ar_hs     = ARVALID_S & ARREADY_S;
  assign RVALID_S  = (cnt_q != 2'd0);
  assign pop       = RVALID_S & RREADY_S;
  assign push      = inflight_q;
  assign occ       = {1'b0, cnt_q} + {2'b00, inflight_q};

  // A beat may issue while fewer than 2 beats are outstanding, counting the slot freed by this cycle's pop.
  assign issue = (state_q == S_BURST) && (issued_q <= {1'b0, len_q}) &&
                 ((occ < 3'd2) || (pop && (occ == 3'd2)));

  assign SRAM_CS   = issue && (resp_q == RESP_OKAY);
  assign SRAM_A    = offset_q[SRAM_AW+1:2];
  assign push_data = (resp_q == RESP_OKAY) ? SRAM_DO : '0;

  assign RID_S     = id_q;
  assign RDATA_S   = d0_q;
  assign RRESP_S   = r0_q;
  assign RLAST_S   = l0_q & RVALID_S;
  assign dbg_state = state_q;

  // Classify the whole burst once: an out-of-window offset wins over an illegal size.
  always_comb begin
    ar_resp = RESP_OKAY;
    if (ar_offset[ADDR_WIDTH-1:SRAM_AW+2] != '0) ar_resp = RESP_DECERR;
    else if (ARSIZE_S != 3'b010)                 ar_resp = RESP_SLVERR;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  // FSM next state and AR ready.
  always_comb begin
    state_d   = state_q;
    ARREADY_S = 1'b0;
    case (state_q)
      S_INIT:  state_d = S_IDLE;
      S_IDLE: begin
        ARREADY_S = 1'b1;
        if (ARVALID_S) state_d = S_BURST;
      end
      S_BURST: if (pop && RLAST_S) state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  // Burst context: latched on AR accept, then the address walks by one word per issued beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q     <= '0;
      len_q    <= '0;
      fixed_q  <= 1'b0;
      offset_q <= '0;
      resp_q   <= RESP_OKAY;
      issued_q <= '0;
    end else if (ar_hs) begin
      id_q     <= ARID_S;
      len_q    <= ARLEN_S;
      fixed_q  <= (ARBURST_S == 2'b00);
      offset_q <= ar_offset;
      resp_q   <= ar_resp;
      issued_q <= '0;
    end else if (issue) begin
      issued_q <= issued_q + {{LEN_WIDTH{1'b0}}, 1'b1};
      if (!fixed_q) offset_q <= offset_q + ADDR_WIDTH'(4);
    end
  end

  // One-cycle read pipeline matching the SRAM latency; error beats ride it without touching the SRAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= (issued_q == {1'b0, len_q});
    end
  end

  // Two-entry skid buffer; entry 0 is the head presented on R.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'd0;
      d0_q  <= '0;
      d1_q  <= '0;
      r0_q  <= 2'b00;
      r1_q  <= 2'b00;
      l0_q  <= 1'b0;
      l1_q  <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            d0_q <= push_data; r0_q <= resp_q; l0_q <= inflight_last_q;
          end else begin
            d1_q <= push_data; r1_q <= resp_q; l1_q <= inflight_last_q;
          end
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          d0_q  <= d1_q; r0_q <= r1_q; l0_q <= l1_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            d0_q <= push_data; r0_q <= resp_q; l0_q <= inflight_last_q;
          end else begin
            d0_q <= d1_q; r0_q <= r1_q; l0_q <= l1_q;
            d1_q <= push_data; r1_q <= resp_q; l1_q <= inflight_last_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_axi_read_engine.sv
// Directed bench for dm_axi_read_engine: SRAM model, AR driver, R monitor, expected queues.
module tb_dm_axi_read_engine;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ARID_S = '0;
  logic [31:0] ARADDR_S = '0;
  logic [3:0]  ARLEN_S = '0;
  logic [2:0]  ARSIZE_S = 3'b010;
  logic [1:0]  ARBURST_S = 2'b01;
  logic        ARVALID_S = 1'b0;
  logic        ARREADY_S;
  logic [7:0]  RID_S;
  logic [31:0] RDATA_S;
  logic [1:0]  RRESP_S;
  logic        RLAST_S, RVALID_S;
  logic        RREADY_S = 1'b1;
  logic        SRAM_CS;
  logic [13:0] SRAM_A;
  logic [31:0] SRAM_DO = '0;
  logic [1:0]  dbg_state;

  dm_axi_read_engine dut (
    .clk(clk), .rst(rst), .BASE_ADDR(BASE),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .SRAM_CS(SRAM_CS), .SRAM_A(SRAM_A), .SRAM_DO(SRAM_DO), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: word at address a holds C0DE_0000 | a, one-cycle read latency
  always @(posedge clk) if (SRAM_CS) SRAM_DO <= 32'hC0DE_0000 | {18'h0, SRAM_A};

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [13:0] exp_a_q[$];
  logic [31:0] obs_data[$];
  logic [1:0]  obs_resp[$];
  logic        obs_last[$];
  logic [7:0]  obs_id[$];
  int          obs_cyc[$];
  logic [13:0] cs_q[$];
  int ar_cyc = 0;
  int cs_total = 0, pop_total = 0, max_out = 0;
  logic hold_v = 1'b0;
  logic [42:0] held = '0;
  int rr_mode = 0, rr_idx = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // R / SRAM monitor, sampled on the falling edge
  always @(negedge clk) begin
    int out_now;
    if (rst) begin
      hold_v = 1'b0; cs_total = 0; pop_total = 0;
    end else begin
      if (hold_v && RVALID_S) check("r_stable", 64'({RID_S, RDATA_S, RRESP_S, RLAST_S}), 64'(held));
      hold_v = RVALID_S & !RREADY_S;
      held = {RID_S, RDATA_S, RRESP_S, RLAST_S};
      if (SRAM_CS) cs_q.push_back(SRAM_A);
      if (RVALID_S && RREADY_S) begin
        obs_data.push_back(RDATA_S); obs_resp.push_back(RRESP_S);
        obs_last.push_back(RLAST_S); obs_id.push_back(RID_S); obs_cyc.push_back(cyc);
      end
      out_now = cs_total + int'(SRAM_CS) - pop_total - int'(RVALID_S && RREADY_S);
      if (out_now > max_out) max_out = out_now;
      cs_total += int'(SRAM_CS);
      pop_total += int'(RVALID_S && RREADY_S);
    end
  end

  // RREADY driver: always 1, or the repeating 1,0,0 pattern
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rr_mode != 0) begin
        RREADY_S = (rr_idx % 3 == 0);
        rr_idx++;
      end else RREADY_S = 1'b1;
    end
  end

  task automatic clear_obs();
    obs_data.delete(); obs_resp.delete(); obs_last.delete(); obs_id.delete();
    obs_cyc.delete(); cs_q.delete(); exp_q.delete(); exp_a_q.delete();
  endtask

  task automatic send_ar(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int k;
    bit done;
    @(posedge clk); #1;
    ARID_S = id; ARADDR_S = addr; ARLEN_S = len; ARSIZE_S = size; ARBURST_S = burst;
    ARVALID_S = 1'b1;
    done = 0;
    for (k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (ARREADY_S) begin ar_cyc = cyc; done = 1; end
    end
    if (!done) check("ar_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    ARVALID_S = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k = 0;
    while (obs_data.size() < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (obs_data.size() < n) check("beat_timeout", 64'(obs_data.size()), 64'(n));
  endtask

  // compare observed beats and SRAM addresses against the expected queues
  task automatic check_burst(input string t, input logic [7:0] id, input logic [1:0] resp);
    int n = exp_q.size();
    check($sformatf("%s_nbeats", t), 64'(obs_data.size()), 64'(n));
    check($sformatf("%s_ncs", t), 64'(cs_q.size()), 64'(exp_a_q.size()));
    for (int i = 0; i < n && i < obs_data.size(); i++) begin
      check($sformatf("%s_data%0d", t, i), 64'(obs_data[i]), 64'(exp_q[i]));
      check($sformatf("%s_resp%0d", t, i), 64'(obs_resp[i]), 64'(resp));
      check($sformatf("%s_last%0d", t, i), 64'(obs_last[i]), 64'(i == n - 1));
      check($sformatf("%s_id%0d", t, i), 64'(obs_id[i]), 64'(id));
    end
    for (int i = 0; i < exp_a_q.size() && i < cs_q.size(); i++)
      check($sformatf("%s_addr%0d", t, i), 64'(cs_q[i]), 64'(exp_a_q[i]));
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arready", 64'(ARREADY_S), 64'(0));
    check("rst_r", 64'({RVALID_S, RLAST_S, RID_S, RDATA_S, RRESP_S}), 64'(0));
    check("rst_sram", 64'({SRAM_CS, SRAM_A}), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("arready_after_rst", 64'(ARREADY_S), 64'(1));

    // 1: INCR, full rate, latency
    clear_obs();
    send_ar(8'h5A, BASE + 32'h10, 4'd3, 3'b010, 2'b01);
    wait_beats(4, 100);
    repeat (3) @(posedge clk); #1;
    exp_a_q = '{14'd4, 14'd5, 14'd6, 14'd7};
    exp_q = '{32'hC0DE_0004, 32'hC0DE_0005, 32'hC0DE_0006, 32'hC0DE_0007};
    check_burst("incr", 8'h5A, 2'b00);
    for (int i = 0; i < 4 && i < obs_cyc.size(); i++)
      check($sformatf("incr_cycle%0d", i), 64'(obs_cyc[i] - ar_cyc - 1), 64'(2 + i));

    // 2: FIXED
    clear_obs();
    send_ar(8'h11, BASE + 32'h8, 4'd2, 3'b010, 2'b00);
    wait_beats(3, 100);
    repeat (3) @(posedge clk); #1;
    exp_a_q = '{14'd2, 14'd2, 14'd2};
    exp_q = '{32'hC0DE_0002, 32'hC0DE_0002, 32'hC0DE_0002};
    check_burst("fixed", 8'h11, 2'b00);

    // 3: backpressure with RREADY 1,0,0,...
    clear_obs();
    max_out = 0; rr_idx = 0; rr_mode = 1;
    send_ar(8'h22, BASE + 32'h40, 4'd7, 3'b010, 2'b01);
    wait_beats(8, 200);
    rr_mode = 0;
    repeat (3) @(posedge clk); #1;
    exp_a_q = '{14'h10, 14'h11, 14'h12, 14'h13, 14'h14, 14'h15, 14'h16, 14'h17};
    exp_q = '{32'hC0DE_0010, 32'hC0DE_0011, 32'hC0DE_0012, 32'hC0DE_0013,
              32'hC0DE_0014, 32'hC0DE_0015, 32'hC0DE_0016, 32'hC0DE_0017};
    check_burst("bp", 8'h22, 2'b00);
    check("bp_max_outstanding", 64'(max_out), 64'(2));

    // 4: DECERR, first byte past the window
    clear_obs();
    send_ar(8'h44, BASE + 32'h1_0000, 4'd1, 3'b010, 2'b01);
    wait_beats(2, 100);
    repeat (3) @(posedge clk); #1;
    exp_q = '{32'h0, 32'h0};
    check_burst("decerr", 8'h44, 2'b11);

    // 5: SLVERR on a narrow size
    clear_obs();
    send_ar(8'h55, BASE, 4'd0, 3'b001, 2'b01);
    wait_beats(1, 100);
    @(negedge clk);
    check("slverr_arready", 64'(ARREADY_S), 64'(1));
    repeat (2) @(posedge clk); #1;
    exp_q = '{32'h0};
    check_burst("slverr", 8'h55, 2'b10);

    // 7: last in-window word, SRAM address wraps mid-burst
    clear_obs();
    send_ar(8'h77, BASE + 32'hFFF8, 4'd2, 3'b010, 2'b10);
    wait_beats(3, 100);
    repeat (3) @(posedge clk); #1;
    exp_a_q = '{14'h3FFE, 14'h3FFF, 14'h0000};
    exp_q = '{32'hC0DE_3FFE, 32'hC0DE_3FFF, 32'hC0DE_0000};
    check_burst("wrap", 8'h77, 2'b00);

    // 6: reset during the 3rd beat, then a fresh burst
    clear_obs();
    send_ar(8'h66, BASE + 32'h20, 4'd5, 3'b010, 2'b01);
    wait_beats(2, 100);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_rvalid", 64'(RVALID_S), 64'(0));
    check("midrst_arready", 64'(ARREADY_S), 64'(0));
    @(negedge clk);
    check("midrst_arready_back", 64'(ARREADY_S), 64'(1));
    clear_obs();
    send_ar(8'h33, BASE + 32'h30, 4'd1, 3'b010, 2'b01);
    wait_beats(2, 100);
    repeat (3) @(posedge clk); #1;
    exp_a_q = '{14'hC, 14'hD};
    exp_q = '{32'hC0DE_000C, 32'hC0DE_000D};
    check_burst("after_rst", 8'h33, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
